// File: rtl/sseg_scan_ctrl.sv
// Seven-segment scan controller: converts a packed hex value one nibble per cycle
// through a shared num2sseg decoder, then commits all digits at once (active-low).
// Optional leading-zero blanking is built when SSEG_LZB_EN is defined.

module num2sseg (
  input  logic [3:0] num,
  output logic [6:0] sseg
);
  // Active-high segments, bit 0 = top, bit 6 = middle.
  always_comb begin
    case (num)
      4'h0:    sseg = 7'h3F;
      4'h1:    sseg = 7'h06;
      4'h2:    sseg = 7'h5B;
      4'h3:    sseg = 7'h4F;
      4'h4:    sseg = 7'h66;
      4'h5:    sseg = 7'h6D;
      4'h6:    sseg = 7'h7D;
      4'h7:    sseg = 7'h07;
      4'h8:    sseg = 7'h7F;
      4'h9:    sseg = 7'h6F;
      4'hA:    sseg = 7'h77;
      4'hB:    sseg = 7'h7C;
      4'hC:    sseg = 7'h39;
      4'hD:    sseg = 7'h5E;
      4'hE:    sseg = 7'h79;
      default: sseg = 7'h71;
    endcase
  end
endmodule

// state  | meaning
// IDLE   | ready for a load; done pulse cleared
// CONV   | decode nibble [idx] into staging, MSB first
// COMMIT | copy staging to hex_out, pulse done
module sseg_scan_ctrl #(
  parameter int NDIGITS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   val_in,
  input  logic                   load_in,
  output logic                   ready_out,
  output logic                   done_out,
  output logic [7*NDIGITS-1:0]   hex_out
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t               state;
  logic [4*NDIGITS-1:0] shadow;
  logic [7*NDIGITS-1:0] staging;
  logic [IW-1:0]        idx;
  logic [3:0]           nib;
  logic [6:0]           dec_seg;
  logic [6:0]           stage_seg;
`ifdef SSEG_LZB_EN
  logic                 seen_nz;
`endif

  always_comb begin
    nib = 4'h0;
    for (int d = 0; d < NDIGITS; d++)
      if (idx == IW'(d)) nib = shadow[4*d +: 4];
  end

  num2sseg u_dec (
    .num  (nib),
    .sseg (dec_seg)
  );

  always_comb begin
    stage_seg = ~dec_seg;
`ifdef SSEG_LZB_EN
    // Digit 0 is never blanked so a zero value still shows "0".
    if (nib == 4'h0 && !seen_nz && idx != '0) stage_seg = 7'h7F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ready_out <= 1'b1;
      done_out  <= 1'b0;
      hex_out   <= '1;
      shadow    <= '0;
      staging   <= '0;
      idx       <= '0;
`ifdef SSEG_LZB_EN
      seen_nz   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_out <= 1'b0;
          if (load_in) begin
            shadow    <= val_in;
            idx       <= IW'(NDIGITS - 1);
`ifdef SSEG_LZB_EN
            seen_nz   <= 1'b0;
`endif
            ready_out <= 1'b0;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          done_out <= 1'b0;
          for (int d = 0; d < NDIGITS; d++)
            if (idx == IW'(d)) staging[7*d +: 7] <= stage_seg;
`ifdef SSEG_LZB_EN
          if (nib != 4'h0) seen_nz <= 1'b1;
`endif
          if (idx == '0) state <= S_COMMIT;
          else           idx   <= idx - IW'(1);
        end
        S_COMMIT: begin
          hex_out   <= staging;
          done_out  <= 1'b1;
          ready_out <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          ready_out <= 1'b1;
          done_out  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (NDIGITS = 6); expectations follow SSEG_LZB_EN.

module tb_sseg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] val_in;
  logic        load_in;
  logic        ready_out;
  logic        done_out;
  logic [41:0] hex_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [41:0] last_exp;

  sseg_scan_ctrl #(.NDIGITS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val_in    (val_in),
    .load_in   (load_in),
    .ready_out (ready_out),
    .done_out  (done_out),
    .hex_out   (hex_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input string tag, input logic [23:0] v, input logic [41:0] exp);
    int w, ndone, lat;
    w = 0;
    while (!ready_out && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_ready_in"}, ready_out, 1);
    val_in = v; load_in = 1'b1;
    tick();
    load_in = 1'b0; val_in = ~v;
    chk({tag, "_busy"}, ready_out, 0);
    ndone = 0; lat = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (done_out) begin ndone++; lat = k; end
      if (k == 6) chk({tag, "_hold"}, hex_out, last_exp);
      if (k == 8) begin
        chk({tag, "_ready_after"}, ready_out, 1);
        chk({tag, "_done_clr"}, done_out, 0);
      end
    end
    chk({tag, "_latency"}, lat, 7);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_hex"}, hex_out, exp);
    last_exp = exp;
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; load_in = 1'b0; val_in = '0;
    last_exp = '1;
    #12;
    chk("rst_hex", hex_out, {42{1'b1}});
    chk("rst_ready", ready_out, 1);
    chk("rst_done", done_out, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_hex", hex_out, {42{1'b1}});
    chk("post_rst_ready", ready_out, 1);

    convert("basic", 24'h123456, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

    // Busy: extra loads at E3 (mid-conversion) and E7 (commit edge) must be dropped.
    val_in = 24'hFFFFFF; load_in = 1'b1;
    tick();
    load_in = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3 || k == 7) begin load_in = 1'b1; val_in = '0; end
      tick();
      load_in = 1'b0; val_in = 24'h5A5A5A;
      if (done_out) ndone++;
      if (k == 7) chk("busy_done_at7", done_out, 1);
      if (k == 10) chk("busy_idle", ready_out, 1);
    end
    chk("busy_ndone", ndone, 1);
    chk("busy_hex", hex_out, {6{7'h0E}});
    last_exp = {6{7'h0E}};

`ifdef SSEG_LZB_EN
    convert("lzb", 24'h000A05, {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12});
    convert("zero", 24'h000000, {{5{7'h7F}}, 7'h40});
`else
    convert("lzb", 24'h000A05, {7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12});
    convert("zero", 24'h000000, {6{7'h40}});
`endif

    // Reset during conversion cycle 3.
    val_in = 24'h654321; load_in = 1'b1;
    tick();
    load_in = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hex", hex_out, {42{1'b1}});
    chk("midrst_ready", ready_out, 1);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done_out) ndone++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done_out) ndone++;
    end
    chk("midrst_ndone", ndone, 0);
    chk("midrst_hex_after", hex_out, {42{1'b1}});
    last_exp = '1;

`ifdef SSEG_LZB_EN
    convert("after_rst", 24'h000001, {{5{7'h7F}}, 7'h79});
`else
    convert("after_rst", 24'h000001, {{5{7'h40}}, 7'h79});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
